// File: rtl/mipi_csi2_pkt_dec.sv
// CSI-2 packet decoder: header parse, VC filter, RAW8/RAW10 unpack to one
// pixel per cycle, line/frame tracking and word-count / CRC error pulses.
// Optional CRC-16 payload check is built only when MIPI_CSI2_CRC_EN is defined.
module mipi_csi2_pkt_dec #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  phy_we,
  input  logic [7:0]            phy_data,
  input  logic [1:0]            vc_sel,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic [15:0]           line_cnt,
  output logic                  wc_err,
  output logic                  crc_err
);
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam bit         RAW10_OK = (DATA_WIDTH == 10);

  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_CRC, ST_EOT} state_t;

  state_t                state_q;
  logic [7:0]            di_q;
  logic [1:0]            hdr_cnt_q;
  logic [15:0]           wc_q;
  logic                  raw10_q;
  logic [2:0]            grp_q;        // bytes held of the current RAW10 group
  logic [3:0][7:0]       acc_q;        // MSB bytes of the group being collected
  logic [2:0][9:0]       drain_q;      // pixels 1..3 of the last complete group
  logic [1:0]            drain_cnt_q;
  logic                  crc_cnt_q;
  logic [DATA_WIDTH-1:0] dato_q;
  logic                  dvo_q, lvo_q, fvo_q, wc_err_q;
  logic [15:0]           line_cnt_q;

  logic        data_acc, grp_done, pix_vld_d, more_px, lvo_d;
  logic [2:0]  grp_nxt;
  logic [15:0] wc_nxt;
  logic [9:0]  pix_d;
  logic [1:0]  drain_left;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;

  assign hdr_vc = di_q[7:6];
  assign hdr_dt = di_q[5:0];

  // Pixel select and "more pixels still to come in this line" for lvo.
  // RAW10 group completion and the drain never overlap since bytes arrive at
  // most one per cycle.
  always_comb begin
    data_acc   = (state_q == ST_DATA) && phy_we;
    grp_nxt    = (grp_q == 3'd4) ? 3'd0 : grp_q + 3'd1;
    wc_nxt     = wc_q - 16'd1;
    grp_done   = data_acc && raw10_q && (grp_q == 3'd4);
    pix_vld_d  = 1'b0;
    pix_d      = '0;
    if (data_acc && !raw10_q) begin
      pix_vld_d = 1'b1;
      pix_d     = {phy_data, 2'b00};
    end else if (grp_done) begin
      pix_vld_d = 1'b1;
      pix_d     = {acc_q[0], phy_data[1:0]};
    end else if (drain_cnt_q != 2'd0) begin
      pix_vld_d = 1'b1;
      pix_d     = drain_q[0];
    end
    if (grp_done)                 drain_left = 2'd3;
    else if (drain_cnt_q != 2'd0) drain_left = drain_cnt_q - 2'd1;
    else                          drain_left = 2'd0;
    // A RAW10 tail too short to finish a group will never produce a pixel.
    more_px = data_acc && (wc_q != 16'd1) &&
              (!raw10_q || (wc_nxt >= (16'd5 - {13'd0, grp_nxt})));
    lvo_d   = pix_vld_d || (lvo_q && ((drain_left != 2'd0) || more_px));
  end

  // Packet FSM with registered pixel, line and frame outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EOT;
      di_q        <= '0;
      hdr_cnt_q   <= '0;
      wc_q        <= '0;
      raw10_q     <= 1'b0;
      grp_q       <= '0;
      acc_q       <= '0;
      drain_q     <= '0;
      drain_cnt_q <= '0;
      crc_cnt_q   <= 1'b0;
      dato_q      <= '0;
      dvo_q       <= 1'b0;
      lvo_q       <= 1'b0;
      fvo_q       <= 1'b0;
      wc_err_q    <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      dvo_q       <= pix_vld_d;
      lvo_q       <= lvo_d;
      drain_cnt_q <= drain_left;
      wc_err_q    <= 1'b0;
      if (pix_vld_d) dato_q <= pix_d[9 -: DATA_WIDTH];
      if (grp_done) begin
        drain_q[0] <= {acc_q[1], phy_data[3:2]};
        drain_q[1] <= {acc_q[2], phy_data[5:4]};
        drain_q[2] <= {acc_q[3], phy_data[7:6]};
      end else if (drain_cnt_q != 2'd0) begin
        drain_q[0] <= drain_q[1];
        drain_q[1] <= drain_q[2];
      end
      if (lvo_q && !lvo_d && (line_cnt_q != 16'hFFFF)) line_cnt_q <= line_cnt_q + 16'd1;

      case (state_q)
        ST_EOT: if (!phy_we) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (!enable) state_q <= ST_EOT;
          else if (phy_we) begin
            di_q      <= phy_data;
            hdr_cnt_q <= 2'd0;
            state_q   <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!phy_we) state_q <= ST_IDLE;
          else begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd0)      wc_q[7:0]  <= phy_data;
            else if (hdr_cnt_q == 2'd1) wc_q[15:8] <= phy_data;
            else begin
              // ECC byte: decode the stored DI, ECC content itself is ignored
              state_q   <= ST_EOT;
              grp_q     <= 3'd0;
              crc_cnt_q <= 1'b0;
              raw10_q   <= (hdr_dt == DT_RAW10);
              if (hdr_vc == vc_sel) begin
                case (hdr_dt)
                  DT_FS: begin
                    fvo_q      <= 1'b1;
                    line_cnt_q <= 16'd0;
                  end
                  DT_FE:    fvo_q   <= 1'b0;
                  DT_RAW8:  state_q <= (wc_q == 16'd0) ? ST_CRC : ST_DATA;
                  DT_RAW10: if (RAW10_OK) state_q <= (wc_q == 16'd0) ? ST_CRC : ST_DATA;
                  default: ;
                endcase
              end
            end
          end
        end
        ST_DATA: begin
          if (!phy_we) begin
            wc_err_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            wc_q  <= wc_nxt;
            grp_q <= grp_nxt;
            if (grp_q != 3'd4) acc_q[grp_q[1:0]] <= phy_data;
            if (wc_q == 16'd1) begin
              state_q <= ST_CRC;
              if (raw10_q && (grp_nxt != 3'd0)) wc_err_q <= 1'b1;
            end
          end
        end
        ST_CRC: begin
          if (!phy_we) state_q <= ST_IDLE;
          else begin
            crc_cnt_q <= 1'b1;
            if (crc_cnt_q) state_q <= ST_EOT;
          end
        end
        default: state_q <= ST_EOT;
      endcase
    end
  end

`ifdef MIPI_CSI2_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  logic [15:0] crc_q;
  logic [7:0]  crc_lo_q;
  logic        crc_err_q;

  // Running CRC over payload bytes, compared with the little-endian trailer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q     <= 16'hFFFF;
      crc_lo_q  <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      if (state_q == ST_HEADER) crc_q <= 16'hFFFF;
      else if (data_acc)        crc_q <= crc16_byte(crc_q, phy_data);
      if ((state_q == ST_CRC) && phy_we) begin
        if (!crc_cnt_q) crc_lo_q  <= phy_data;
        else            crc_err_q <= (crc_q != {phy_data, crc_lo_q});
      end
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign dato     = dato_q;
  assign dvo      = dvo_q;
  assign lvo      = lvo_q;
  assign fvo      = fvo_q;
  assign line_cnt = line_cnt_q;
  assign wc_err   = wc_err_q;
endmodule
